// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch front end.
//   INST_W        instruction width in bits
//   PC_INC        byte increment between sequential instructions
//   PC_W_MAX      widest PC the buffer entry can carry
//   fetch_entry_t one buffered fetch: returned instruction plus its PC.
//                 The PC field is sized for the widest supported PC. Narrower
//                 configurations zero-extend into it and ignore the upper bits.
package fetch_pkg;

   localparam int INST_W   = 32;
   localparam int PC_INC   = 4;
   localparam int PC_W_MAX = 64;

   typedef struct packed {
      logic [INST_W-1:0]   inst;
      logic [PC_W_MAX-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t for the fetch stage.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      drop all entries. Takes priority over push and pop
//   push       write push_data at the tail (ignored when full)
//   push_data  entry to write
//   pop        remove the head entry (ignored when empty)
//   head       head entry, all zeros while empty
//   count      number of valid entries (0..DEPTH)
//   empty/full occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Zero head while empty keeps the downstream instruction/PC outputs at a
   // known value after reset and after a flush.
   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !clear && do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Owns the byte-addressed PC,
// issues word fetches to a variable-latency in-order instruction memory, and
// buffers returned instructions with their PC for decode.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_req_valid    fetch request valid (never depends on imem_req_ready)
//   imem_req_ready    memory accepts the request
//   imem_req_addr     fetch byte address (word aligned)
//   imem_rsp_valid    response valid, in request order, never back-pressured
//   imem_rsp_data     returned instruction
//   redirect_valid    taken branch/jump this cycle, flushes everything
//   redirect_pc       redirect target (low two bits are cleared)
//   inst_valid        instruction available to decode
//   inst_ready        decode accepts the instruction
//   inst, inst_pc     FIFO head instruction and its PC
//   misalign_err      sticky misaligned-redirect flag, present only when
//                     FETCH_ALIGN_CHECK_EN is defined
// Build option: define FETCH_ALIGN_CHECK_EN to add misalign_err.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A valid source holds its payload until the transfer. The
// memory response channel has no ready and must always be accepted.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [PC_W-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [PC_W-1:0]   inst_pc
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic              misalign_err
`endif
);

   localparam int              CW      = $clog2(DEPTH+1);
   localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

   logic [PC_W-1:0] fetch_pc;
   logic [PC_W-1:0] rsp_pc;
   logic [PC_W-1:0] target_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_next;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     credits_used;
   logic            req_fire;
   logic            push;
   logic            pop;
   logic            fifo_empty;
   logic            fifo_full;
   fetch_entry_t    push_data;
   fetch_entry_t    head;
   logic            unused_bits;

   assign target_pc = {redirect_pc[PC_W-1:2], 2'b00};

   // Credit rule: buffered plus in-flight fetches never exceed DEPTH, so
   // every response that is kept has a free FIFO slot waiting for it.
   assign credits_used   = {1'b0, fifo_count} + {1'b0, outstanding};
   assign imem_req_valid = ~rst & (credits_used < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

   // Responses to fetches issued before the last redirect are stale and are
   // dropped while drop_cnt is non-zero. A response arriving in the redirect
   // cycle itself is stale as well.
   assign push = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0);

   always_comb begin
      push_data                = '0;
      push_data.inst           = imem_rsp_data;
      push_data.pc[PC_W-1:0]   = rsp_pc;
   end

   // The head is hidden during a redirect so decode never consumes a
   // wrong-path instruction in the cycle the flush happens.
   assign inst_valid = ~fifo_empty & ~redirect_valid;
   assign pop        = inst_valid & inst_ready;
   assign inst       = head.inst;
   assign inst_pc    = head.pc[PC_W-1:0];

   assign unused_bits = ^{head.pc, fifo_full, redirect_pc[1:0]};

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect_valid),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            fetch_pc <= target_pc;
            rsp_pc   <= target_pc;
            // Every fetch still in flight after this edge belongs to the
            // old path, including one accepted in this very cycle.
            drop_cnt <= outstanding_next;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
            if (push)     rsp_pc   <= rsp_pc + PC_STEP;
            if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_err <= 1'b0;
      end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         misalign_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a behavioural in-order
// instruction memory (configurable latency, data = addr ^ 32'hA5A5A5A5).
// A single DUT is built with RESET_PC = 0x400, so sequential streams start
// there. Inputs change only on the falling edge; outputs are sampled 1 ns
// after it.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_err;
`endif

   int checks    = 0;
   int failures  = 0;
   int mem_lat   = 1;
   int mem_t     = 0;
   int req_count = 0;

   logic [63:0] exp_q[$];
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];

   fetch_stage #(
      .PC_W     (32),
      .DEPTH    (4),
      .RESET_PC (32'h400)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .misalign_err   (misalign_err)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      forever begin
         @(negedge clk);
         mem_t++;
         if (mem_due_q.size() != 0 && mem_due_q[0] == mem_t) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr_q.pop_front() ^ 32'hA5A5A5A5;
            void'(mem_due_q.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
         end
         #1;
         if (rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
            imem_rsp_valid = 1'b0;
         end else if (imem_req_valid && imem_req_ready) begin
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(mem_t + mem_lat);
            req_count++;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL inst_unexpected got pc=%h inst=%h expected no delivery", inst_pc, inst);
            end else begin
               exp = exp_q.pop_front();
               if ({inst, inst_pc} !== exp) begin
                  failures++;
                  $display("FAIL inst_stream got pc=%h inst=%h expected pc=%h inst=%h",
                           inst_pc, inst, exp[31:0], exp[63:32]);
               end
            end
         end
      end
   end

   // ---------------- driver / check tasks ----------------
   task automatic push_exp(input logic [31:0] pc);
      exp_q.push_back({pc ^ 32'hA5A5A5A5, pc});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Leaves the caller at the falling edge that starts cycle 0 after reset.
   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;
      imem_req_ready = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      rst = 1'b0;
   endtask

   // Waits until every expected instruction is delivered, then stops decode.
   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got %0d undelivered expected 0", name, exp_q.size());
         exp_q.delete();
      end
      inst_ready = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      // Streaming: 1-cycle memory, decode always ready.
      do_reset();
      mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 10; i++) push_exp(32'h400 + 32'(4 * i));
      #1;
      check("reset_req_valid", imem_req_valid, 32'h1);
      check("reset_req_addr", imem_req_addr, 32'h400);
      @(negedge clk); #1;
      check("stream_latency_c1", inst_valid, 32'h0);
      repeat (11) @(negedge clk);
      inst_ready = 1'b0;
      #1;
      check("stream_no_gaps", 32'(exp_q.size()), 32'h0);
      exp_q.delete();

      // Backpressure: decode stalled, credits cap requests at four.
      do_reset();
      mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0; req_count = 0;
      repeat (8) @(negedge clk);
      #1;
      check("bp_req_count", 32'(req_count), 32'h4);
      check("bp_req_valid", imem_req_valid, 32'h0);
      check("bp_req_addr", imem_req_addr, 32'h410);
      check("bp_inst_valid", inst_valid, 32'h1);
      check("bp_head_pc", inst_pc, 32'h400);
      @(negedge clk);
      for (int i = 0; i < 8; i++) push_exp(32'h400 + 32'(4 * i));
      inst_ready = 1'b1;
      drain("bp", 40);

      // Flush: 3-cycle memory, three fetches in flight, redirect to 0x100.
      do_reset();
      mem_lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_exp(32'h100 + 32'(4 * i));
      repeat (3) @(negedge clk);
      imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
      #1;
      check("flush_inst_valid", inst_valid, 32'h0);
      @(negedge clk);
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      #1;
      check("flush_req_addr", imem_req_addr, 32'h100);
      drain("flush", 40);

      // Simultaneous redirect, request fire and response, FIFO non-empty.
      do_reset();
      mem_lat = 2; imem_req_ready = 1'b1; inst_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_exp(32'h200 + 32'(4 * i));
      repeat (3) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
      #1;
      check("sim_inst_valid", inst_valid, 32'h0);
      check("sim_req_valid", imem_req_valid, 32'h1);
      check("sim_req_addr_old", imem_req_addr, 32'h40C);
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      check("sim_req_addr_new", imem_req_addr, 32'h200);
      drain("sim", 40);

      // Reset mid-stream with a full FIFO.
      do_reset();
      mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      check("rst_fifo_full", inst_valid, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_req_valid_held", imem_req_valid, 32'h0);
      @(negedge clk); #1;
      check("rst_inst_valid", inst_valid, 32'h0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_req_addr", imem_req_addr, 32'h400);
`ifdef FETCH_ALIGN_CHECK_EN
      check("rst_misalign", misalign_err, 32'h0);
`endif
      @(negedge clk);
      rst = 1'b0; inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_exp(32'h400 + 32'(4 * i));
      drain("rst_restart", 40);

      // Misaligned redirect, then a redirect that wraps the PC.
      do_reset();
      mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) push_exp(32'h100 + 32'(4 * i));
      #1;
`ifdef FETCH_ALIGN_CHECK_EN
      check("align_err_reset", misalign_err, 32'h0);
`endif
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      #1;
`ifdef FETCH_ALIGN_CHECK_EN
      check("align_err_registered", misalign_err, 32'h0);
`endif
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      check("align_resume_addr", imem_req_addr, 32'h100);
`ifdef FETCH_ALIGN_CHECK_EN
      check("align_err_set", misalign_err, 32'h1);
`endif
      drain("align", 40);
      push_exp(32'hFFFF_FFF8);
      push_exp(32'hFFFF_FFFC);
      push_exp(32'h0000_0000);
      push_exp(32'h0000_0004);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; inst_ready = 1'b1;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
`ifdef FETCH_ALIGN_CHECK_EN
      check("align_err_sticky", misalign_err, 32'h1);
`endif
      drain("wrap", 40);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
